// File: rtl/pll_reconfig_sequencer_pkg.sv
// pll_reconfig_pkg: shared definitions for the pixel-clock PLL reconfiguration
// sequencer. It holds the reconfig controller register map, the divider
// profile record, the four preset frequency profiles and the sequencer
// state encoding.
package pll_reconfig_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  // Reconfig controller management-port word addresses
  localparam logic [ADDR_W-1:0] ADDR_MODE   = 6'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 6'd1;
  localparam logic [ADDR_W-1:0] ADDR_START  = 6'd2;
  localparam logic [ADDR_W-1:0] ADDR_N      = 6'd3;
  localparam logic [ADDR_W-1:0] ADDR_M      = 6'd4;
  localparam logic [ADDR_W-1:0] ADDR_C      = 6'd5;
  localparam logic [ADDR_W-1:0] ADDR_K      = 6'd7;

  localparam logic [DATA_W-1:0] MODE_POLLING     = 32'd1;
  localparam logic [DATA_W-1:0] START_GO         = 32'd1;
  localparam logic [DATA_W-1:0] STATUS_DONE_MASK = 32'h0000_0001;

  // Divider words: [17] odd, [16] bypass, [15:8] hi, [7:0] lo.
  // C words additionally carry the counter select in [22:18] (C0 = 0).
  typedef struct packed {
    logic [DATA_W-1:0] n_word;
    logic [DATA_W-1:0] m_word;
    logic [DATA_W-1:0] c0_word;
    logic [DATA_W-1:0] k_word;
  } profile_t;

  localparam profile_t PROFILE_ROM [0:3] = '{
    // 148.5 MHz: N bypass, M 4/4, C0 2/1 odd
    '{n_word: 32'h0001_0000, m_word: 32'h0000_0404,
      c0_word: 32'h0002_0201, k_word: 32'd3908420153},
    // 74.25 MHz: C0 3/3
    '{n_word: 32'h0001_0000, m_word: 32'h0000_0404,
      c0_word: 32'h0000_0303, k_word: 32'd3908420153},
    // 25.0 MHz: M 5/5, integer mode, C0 10/10
    '{n_word: 32'h0001_0000, m_word: 32'h0000_0505,
      c0_word: 32'h0000_0A0A, k_word: 32'd0},
    // 49.5 MHz: C0 5/4 odd
    '{n_word: 32'h0001_0000, m_word: 32'h0000_0404,
      c0_word: 32'h0002_0504, k_word: 32'd3908420153}
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_N,
    ST_WR_M,
    ST_WR_C,
    ST_WR_K,
    ST_WR_START,
    ST_POLL_RD,
    ST_POLL_GAP,
    ST_LOCK_WAIT,
    ST_DONE,
    ST_ERR
  } seq_state_t;

endpackage

// File: rtl/pll_reconfig_sequencer_if.sv
// pll_reconfig_sequencer_if: Avalon-MM management port of the PLL reconfig
// controller.
//   mgmt_address/write/read/writedata : master -> controller
//   mgmt_readdata/waitrequest         : controller -> master
interface pll_reconfig_sequencer_if;
  import pll_reconfig_pkg::*;

  logic [ADDR_W-1:0] mgmt_address;
  logic              mgmt_write;
  logic              mgmt_read;
  logic [DATA_W-1:0] mgmt_writedata;
  logic [DATA_W-1:0] mgmt_readdata;
  logic              mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
    input  mgmt_readdata, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
    output mgmt_readdata, mgmt_waitrequest
  );

endinterface

// File: rtl/pll_reconfig_sequencer_avmm_single_master.sv
// avmm_single_master: issues one Avalon-MM read or write per start pulse.
//   clk, rst      : clock, async active-high reset
//   start         : one-cycle command strobe, taken only when the bus is idle
//   wr/addr/wdata : command (wr=1 write, wr=0 read)
//   ack           : one-cycle pulse the cycle after the transfer completes
//   rdata         : captured read data, valid with ack for reads
//   bus           : management port (master side)
module avmm_single_master
  import pll_reconfig_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  pll_reconfig_sequencer_if.master bus
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mgmt_address   <= '0;
      bus.mgmt_write     <= 1'b0;
      bus.mgmt_read      <= 1'b0;
      bus.mgmt_writedata <= '0;
      ack                <= 1'b0;
      rdata              <= '0;
    end else begin
      ack <= 1'b0;
      if (bus.mgmt_write || bus.mgmt_read) begin
        // Everything is held while stalled; the transfer retires on the
        // first cycle without waitrequest.
        if (!bus.mgmt_waitrequest) begin
          if (bus.mgmt_read) rdata <= bus.mgmt_readdata;
          bus.mgmt_address   <= '0;
          bus.mgmt_write     <= 1'b0;
          bus.mgmt_read      <= 1'b0;
          bus.mgmt_writedata <= '0;
          ack                <= 1'b1;
        end
      end else if (start) begin
        bus.mgmt_address   <= addr;
        bus.mgmt_write     <= wr;
        bus.mgmt_read      <= !wr;
        bus.mgmt_writedata <= wr ? wdata : '0;
      end
    end
  end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer: loads one of four PLL frequency profiles through the
// reconfig controller, starts the reconfiguration, polls STATUS, then waits
// for a stable PLL lock.
//   clk, rst        : management clock, async active-high reset
//   req/profile_sel : start pulse and profile index (ignored while busy)
//   busy/done/error : sequence in progress / success pulse / sticky failure
//   active_profile  : last successfully applied profile
//   pll_locked      : asynchronous PLL lock, synchronised here
//   mgmt            : management port (master side)
//
// state        | meaning
// IDLE         | waiting for req
// WR_MODE      | writing MODE = polling
// WR_N..WR_K   | writing the N, M, C0 and K divider words
// WR_START     | writing START = 1
// POLL_RD      | reading STATUS
// POLL_GAP     | idle spacing between STATUS reads
// LOCK_WAIT    | counting consecutive synchronised lock cycles
// DONE         | one-cycle success, done pulse
// ERR          | one-cycle timeout, error set
module pll_reconfig_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 1048576,
  parameter int POLL_GAP           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] profile_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] active_profile,
  input  logic       pll_locked,
  pll_reconfig_sequencer_if.master mgmt
);

  localparam int TMO_W  = 21;
  localparam int LOCK_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);

  // Down-counters are loaded with N-1 so terminal count 0 marks the Nth cycle
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(POLL_GAP - 1);

  seq_state_t        state;
  logic [1:0]        prof_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              lock_meta, lock_s;

  logic              cmd_start, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              mst_ack;
  logic [DATA_W-1:0] mst_rdata;

  profile_t prof;
  logic     tmo_hit, status_done;

  assign prof        = PROFILE_ROM[prof_q];
  assign tmo_hit     = (tmo_cnt == '0);
  assign status_done = ((mst_rdata & STATUS_DONE_MASK) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  avmm_single_master u_master (
    .clk   (clk),
    .rst   (rst),
    .start (cmd_start),
    .wr    (cmd_write),
    .addr  (cmd_addr),
    .wdata (cmd_wdata),
    .ack   (mst_ack),
    .rdata (mst_rdata),
    .bus   (mgmt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      active_profile <= '0;
      prof_q         <= '0;
      tmo_cnt        <= '0;
      lock_cnt       <= '0;
      gap_cnt        <= '0;
      cmd_start      <= 1'b0;
      cmd_write      <= 1'b0;
      cmd_addr       <= '0;
      cmd_wdata      <= '0;
    end else begin
      cmd_start <= 1'b0;
      done      <= 1'b0;
      // Free-running decrement; reloaded on entry to POLL_RD and LOCK_WAIT
      if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          if (req) begin
            state     <= ST_WR_MODE;
            busy      <= 1'b1;
            error     <= 1'b0;
            prof_q    <= profile_sel;
            cmd_start <= 1'b1;
            cmd_write <= 1'b1;
            cmd_addr  <= ADDR_MODE;
            cmd_wdata <= MODE_POLLING;
          end
        end
        ST_WR_MODE: begin
          if (mst_ack) begin
            state     <= ST_WR_N;
            cmd_start <= 1'b1;
            cmd_addr  <= ADDR_N;
            cmd_wdata <= prof.n_word;
          end
        end
        ST_WR_N: begin
          if (mst_ack) begin
            state     <= ST_WR_M;
            cmd_start <= 1'b1;
            cmd_addr  <= ADDR_M;
            cmd_wdata <= prof.m_word;
          end
        end
        ST_WR_M: begin
          if (mst_ack) begin
            state     <= ST_WR_C;
            cmd_start <= 1'b1;
            cmd_addr  <= ADDR_C;
            cmd_wdata <= prof.c0_word;
          end
        end
        ST_WR_C: begin
          if (mst_ack) begin
            state     <= ST_WR_K;
            cmd_start <= 1'b1;
            cmd_addr  <= ADDR_K;
            cmd_wdata <= prof.k_word;
          end
        end
        ST_WR_K: begin
          if (mst_ack) begin
            state     <= ST_WR_START;
            cmd_start <= 1'b1;
            cmd_addr  <= ADDR_START;
            cmd_wdata <= START_GO;
          end
        end
        ST_WR_START: begin
          if (mst_ack) begin
            state     <= ST_POLL_RD;
            tmo_cnt   <= TMO_LOAD;
            cmd_start <= 1'b1;
            cmd_write <= 1'b0;
            cmd_addr  <= ADDR_STATUS;
            cmd_wdata <= '0;
          end
        end
        ST_POLL_RD: begin
          // Timeout is only honoured once the read has retired so an
          // accepted bus transfer is never abandoned.
          if (mst_ack) begin
            if (status_done) begin
              state    <= ST_LOCK_WAIT;
              lock_cnt <= LOCK_LOAD;
              tmo_cnt  <= TMO_LOAD;
            end else if (tmo_hit) begin
              state <= ST_ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= ST_POLL_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        ST_POLL_GAP: begin
          if (tmo_hit) begin
            state <= ST_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else if (gap_cnt == '0) begin
            state     <= ST_POLL_RD;
            cmd_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_LOCK_WAIT: begin
          if (lock_s && lock_cnt == '0) begin
            state          <= ST_DONE;
            done           <= 1'b1;
            busy           <= 1'b0;
            active_profile <= prof_q;
          end else if (tmo_hit) begin
            state <= ST_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else if (lock_s) begin
            lock_cnt <= lock_cnt - 1'b1;
          end else begin
            lock_cnt <= LOCK_LOAD;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ERR:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Testbench for pll_reconfig_sequencer: table of profile vectors plus directed
// sequences for waitrequest stalls, STATUS polling, lock drop, timeout and
// mid-transaction reset.
module tb_pll_reconfig_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] profile_sel;
  logic       busy, done, error;
  logic [1:0] active_profile;
  logic       pll_locked;

  pll_reconfig_sequencer_if mgmt_bus ();

  pll_reconfig_sequencer #(
    .LOCK_STABLE_CYCLES (1024),
    .TIMEOUT_CYCLES     (4000),
    .POLL_GAP           (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .profile_sel    (profile_sel),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .active_profile (active_profile),
    .pll_locked     (pll_locked),
    .mgmt           (mgmt_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] n_exp;
    logic [31:0] m_exp;
    logic [31:0] c_exp;
    logic [31:0] k_exp;
  } prof_vec_t;

  prof_vec_t vecs [4];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [5:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          rd_cyc_q  [$];

  int stall_addr = -1;
  int stall_left = 0;
  int zero_reads = 0;
  int reads_done = 0;
  int conflicts  = 0;
  int m_hold     = 0;
  int m_unstable = 0;
  int done_cyc   = 0;
  int err_cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reconfig controller model: optional stall on one address, STATUS reads
  // return 0 for the first zero_reads reads, then 1.
  always @(posedge clk) begin
    #1;
    if (mgmt_bus.mgmt_write && int'(mgmt_bus.mgmt_address) == stall_addr && stall_left > 0) begin
      mgmt_bus.mgmt_waitrequest = 1'b1;
      stall_left--;
    end else begin
      mgmt_bus.mgmt_waitrequest = 1'b0;
    end
    mgmt_bus.mgmt_readdata = (mgmt_bus.mgmt_read && reads_done >= zero_reads) ? 32'h1 : 32'h0;
  end

  always @(negedge clk) begin
    if (mgmt_bus.mgmt_write && mgmt_bus.mgmt_read) conflicts++;
    if (mgmt_bus.mgmt_write === 1'b1 && mgmt_bus.mgmt_waitrequest === 1'b0) begin
      wr_addr_q.push_back(mgmt_bus.mgmt_address);
      wr_data_q.push_back(mgmt_bus.mgmt_writedata);
    end
    if (mgmt_bus.mgmt_read === 1'b1 && mgmt_bus.mgmt_waitrequest === 1'b0) begin
      rd_cyc_q.push_back(cyc);
      reads_done++;
    end
    if (mgmt_bus.mgmt_write === 1'b1 && mgmt_bus.mgmt_address == 6'd4) begin
      m_hold++;
      if (mgmt_bus.mgmt_writedata !== 32'h0000_0404) m_unstable++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_cyc_q.delete();
    reads_done = 0;
    m_hold     = 0;
    m_unstable = 0;
  endtask

  task automatic pulse_req(input logic [1:0] p);
    @(posedge clk); #2;
    req = 1'b1;
    profile_sel = p;
    @(posedge clk); #2;
    req = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin got_done = 1'b1; done_cyc = cyc; break; end
      if (error) begin got_err = 1'b1; err_cyc = cyc; break; end
    end
  endtask

  task automatic check_writes(input string tag, input prof_vec_t v);
    logic [5:0]  ea [6];
    logic [31:0] ed [6];
    ea = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd2};
    ed = '{32'd1, v.n_exp, v.m_exp, v.c_exp, v.k_exp, 32'd1};
    chk({tag, " write count"}, wr_addr_q.size(), 6);
    if (wr_addr_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("%s wr%0d addr", tag, k), wr_addr_q[k], ea[k]);
        chk($sformatf("%s wr%0d data", tag, k), wr_data_q[k], ed[k]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit gd, ge;
    int lat, low_end, t0, n4;

    vecs[0] = '{2'd0, 32'h0001_0000, 32'h0000_0404, 32'h0002_0201, 32'd3908420153};
    vecs[1] = '{2'd1, 32'h0001_0000, 32'h0000_0404, 32'h0000_0303, 32'd3908420153};
    vecs[2] = '{2'd2, 32'h0001_0000, 32'h0000_0505, 32'h0000_0A0A, 32'd0};
    vecs[3] = '{2'd3, 32'h0001_0000, 32'h0000_0404, 32'h0002_0504, 32'd3908420153};

    rst = 1'b1;
    req = 1'b0;
    profile_sel = 2'd0;
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    chk("reset active_profile", active_profile, 0);
    chk("reset mgmt_address", mgmt_bus.mgmt_address, 0);
    chk("reset mgmt_write", mgmt_bus.mgmt_write, 0);
    chk("reset mgmt_read", mgmt_bus.mgmt_read, 0);
    chk("reset mgmt_writedata", mgmt_bus.mgmt_writedata, 0);
    @(negedge clk);
    rst = 1'b0;
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);

    // Table: each profile, no stalls, STATUS done on first read, lock held
    for (int i = 0; i < 4; i++) begin
      clear_log();
      zero_reads = 0;
      pulse_req(vecs[i].sel);
      if (i == 1) begin
        // Request while busy must be dropped
        repeat (3) @(posedge clk); #2;
        req = 1'b1;
        profile_sel = 2'd3;
        @(posedge clk); #2;
        req = 1'b0;
      end
      wait_end(3000, gd, ge);
      chk($sformatf("p%0d done", i), gd, 1);
      chk($sformatf("p%0d no error", i), ge, 0);
      chk($sformatf("p%0d busy low at done", i), busy, 0);
      chk($sformatf("p%0d active_profile", i), active_profile, vecs[i].sel);
      repeat (2) @(negedge clk);
      chk($sformatf("p%0d done one cycle", i), done, 0);
      check_writes($sformatf("p%0d", i), vecs[i]);
      lat = (rd_cyc_q.size() > 0) ? done_cyc - rd_cyc_q[rd_cyc_q.size() - 1] : -1;
      chk($sformatf("p%0d lock latency in 1024..1030 (lat=%0d)", i, lat), (lat >= 1024 && lat <= 1030), 1);
    end

    // Stall on the M write for 5 cycles
    clear_log();
    stall_addr = 4;
    stall_left = 5;
    pulse_req(2'd0);
    wait_end(3000, gd, ge);
    chk("stall done", gd, 1);
    chk("stall M write held cycles", m_hold, 6);
    chk("stall M data unstable cycles", m_unstable, 0);
    n4 = 0;
    foreach (wr_addr_q[k]) if (wr_addr_q[k] == 6'd4) n4++;
    chk("stall M writes accepted", n4, 1);
    check_writes("stall", vecs[0]);
    stall_addr = -1;

    // STATUS busy three times before done
    clear_log();
    zero_reads = 3;
    pulse_req(2'd1);
    wait_end(3000, gd, ge);
    chk("poll done", gd, 1);
    chk("poll read count", rd_cyc_q.size(), 4);
    if (rd_cyc_q.size() == 4) begin
      for (int k = 1; k < 4; k++)
        chk($sformatf("poll gap %0d >= 17 (gap=%0d)", k, rd_cyc_q[k] - rd_cyc_q[k-1]),
            (rd_cyc_q[k] - rd_cyc_q[k-1] >= 17), 1);
    end
    chk("poll active_profile", active_profile, 1);

    // Lock drops once about 500 cycles into LOCK_WAIT
    clear_log();
    zero_reads = 0;
    pulse_req(2'd2);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (reads_done > 0) break;
    end
    chk("lock status read seen", (reads_done > 0), 1);
    repeat (500) @(posedge clk);
    #1 pll_locked = 1'b0;
    @(posedge clk);
    #1 pll_locked = 1'b1;
    low_end = cyc;
    wait_end(3000, gd, ge);
    chk("lock drop done", gd, 1);
    chk($sformatf("lock drop restart (%0d cycles)", done_cyc - low_end), (done_cyc - low_end >= 1024), 1);
    chk("lock drop active_profile", active_profile, 2);

    // STATUS never completes: timeout
    clear_log();
    zero_reads = 1000000;
    pulse_req(2'd1);
    t0 = cyc;
    wait_end(6000, gd, ge);
    chk("timeout error", ge, 1);
    chk("timeout no done", gd, 0);
    chk("timeout busy", busy, 0);
    chk("timeout active_profile kept", active_profile, 2);
    chk($sformatf("timeout latency (%0d)", err_cyc - t0), (err_cyc - t0 >= 4000 && err_cyc - t0 <= 4060), 1);
    repeat (20) @(negedge clk);
    chk("error sticky", error, 1);
    clear_log();
    zero_reads = 0;
    pulse_req(2'd3);
    chk("error cleared by req", error, 0);
    chk("busy after req", busy, 1);
    wait_end(3000, gd, ge);
    chk("post timeout done", gd, 1);
    chk("post timeout active_profile", active_profile, 3);

    // Reset during the stalled K write
    clear_log();
    stall_addr = 7;
    stall_left = 100000;
    pulse_req(2'd3);
    gd = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mgmt_bus.mgmt_write && mgmt_bus.mgmt_address == 6'd7) begin gd = 1'b1; break; end
    end
    chk("K write stall reached", gd, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst mgmt_write", mgmt_bus.mgmt_write, 0);
    chk("rst mgmt_read", mgmt_bus.mgmt_read, 0);
    chk("rst mgmt_address", mgmt_bus.mgmt_address, 0);
    chk("rst mgmt_writedata", mgmt_bus.mgmt_writedata, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    stall_left = 0;
    stall_addr = -1;
    repeat (3) @(negedge clk);
    clear_log();
    pulse_req(2'd2);
    wait_end(3000, gd, ge);
    chk("after reset done", gd, 1);
    chk("after reset active_profile", active_profile, 2);
    check_writes("after reset", vecs[2]);

    chk("read/write never together", conflicts, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
